// File: rtl/ht16d35a_cmd_sequencer.sv
// rtl/ht16d35a_cmd_sequencer.sv - HT16D35A init/display-write command sequencer
//
// Sits in front of the HT16D35A SPI controller. After reset it idles POR_WAIT
// cycles, plays a fixed five-entry init ROM to all chips, optionally clears the
// display RAM, raises init_done and then turns each application write request
// into one controller transaction.
//
// Optional feature macro: HT16D35A_SEQ_CLEAR_EN (RAM-clear writes after init).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   activate              transaction request to the controller (held until busy)
//   in_cs                 active-high chip mask for the transaction
//   out_data, out_count   transaction bytes (byte 0 first) and valid byte count
//   busy                  controller busy
//   init_done             init (and clear, if enabled) complete
//   req_valid, req_ready  application write request handshake
//   req_cs, req_addr      target chips, display RAM start address
//   req_data, req_len     payload bytes and payload count (1..5)

module ht16d35a_cmd_sequencer #(
    parameter int         NUM_SELECTS     = 2,
    parameter int         OUT_BYTES       = 8,
    parameter int         OUT_BYTES_SZ    = $clog2(OUT_BYTES),
    parameter int         POR_WAIT        = 50000,
    parameter int         SETTLE_WAIT     = 500,
    parameter int         GAP_WAIT        = 100,
    parameter logic [7:0] CLEAR_LAST_ADDR = 8'h1F
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         activate,
    output logic [NUM_SELECTS-1:0]       in_cs,
    output logic [OUT_BYTES-1:0][7:0]    out_data,
    output logic [OUT_BYTES_SZ-1:0]      out_count,
    input  logic                         busy,
    output logic                         init_done,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NUM_SELECTS-1:0]       req_cs,
    input  logic [7:0]                   req_addr,
    input  logic [4:0][7:0]              req_data,
    input  logic [2:0]                   req_len
);

`ifdef HT16D35A_SEQ_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    localparam logic [31:0] POR_LAST    = 32'(POR_WAIT - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_WAIT - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_WAIT - 1);

    typedef enum logic [2:0] {
        S_POR_WAIT,
        S_LOAD,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_IDLE
    } state_t;

    // What the transaction in flight belongs to; decides where S_GAP goes next.
    typedef enum logic [1:0] {
        PH_INIT,
        PH_CLEAR,
        PH_REQ
    } phase_t;

    state_t      state;
    phase_t      phase;
    logic [31:0] cnt;
    logic [2:0]  rom_idx;
    logic [7:0]  clr_addr;

    logic [OUT_BYTES-1:0][7:0] load_data;
    logic [OUT_BYTES_SZ-1:0]   load_count;
    logic [OUT_BYTES-1:0][7:0] req_load_data;
    logic [OUT_BYTES_SZ-1:0]   req_load_count;
    logic                      req_drop;
    logic [31:0]               gap_last;
    logic                      clear_last;

    // Init ROM / RAM-clear transaction contents for S_LOAD.
    always_comb begin
        load_data  = '0;
        load_count = '0;
        if (phase == PH_CLEAR) begin
            load_data[0] = 8'h80;
            load_data[1] = clr_addr;
            load_count   = OUT_BYTES_SZ'(6);
        end else begin
            case (rom_idx)
                3'd0: begin
                    load_data[0] = 8'hCC;
                    load_count   = OUT_BYTES_SZ'(1);
                end
                3'd1: begin
                    load_data[0] = 8'h35;
                    load_data[1] = 8'h02;
                    load_count   = OUT_BYTES_SZ'(2);
                end
                3'd2: begin
                    load_data[0] = 8'h41;
                    load_data[1] = 8'h0F;
                    load_count   = OUT_BYTES_SZ'(2);
                end
                3'd3: begin
                    load_data[0] = 8'h37;
                    load_data[1] = 8'h40;
                    load_count   = OUT_BYTES_SZ'(2);
                end
                default: begin
                    load_data[0] = 8'h35;
                    load_data[1] = 8'h03;
                    load_count   = OUT_BYTES_SZ'(2);
                end
            endcase
        end
    end

    // Write-request transaction: 80, address, then req_len payload bytes.
    always_comb begin
        req_load_data    = '0;
        req_load_data[0] = 8'h80;
        req_load_data[1] = req_addr;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < req_len) begin
                req_load_data[i + 2] = req_data[i];
            end
        end
        req_load_count = OUT_BYTES_SZ'(req_len) + OUT_BYTES_SZ'(2);
        req_drop       = (req_len == 3'd0) || (req_len > 3'd5) || (req_cs == '0);
    end

    // The software-reset command (ROM entry 0) needs the longer settle time.
    assign gap_last   = (phase == PH_INIT && rom_idx == 3'd0) ? SETTLE_LAST : GAP_LAST;
    assign clear_last = ({1'b0, clr_addr} + 9'd4) > {1'b0, CLEAR_LAST_ADDR};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_POR_WAIT;
            phase     <= PH_INIT;
            cnt       <= '0;
            rom_idx   <= '0;
            clr_addr  <= '0;
            activate  <= 1'b0;
            in_cs     <= '0;
            out_data  <= '0;
            out_count <= '0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                S_POR_WAIT: begin
                    if (cnt == POR_LAST) begin
                        cnt     <= '0;
                        rom_idx <= '0;
                        phase   <= PH_INIT;
                        state   <= S_LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LOAD: begin
                    in_cs     <= '1;
                    out_data  <= load_data;
                    out_count <= load_count;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!busy) begin
                        activate <= 1'b1;
                        state    <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    // Controller only samples activate on its half-bit tick,
                    // so hold it until busy proves it was seen.
                    if (busy) begin
                        activate <= 1'b0;
                        state    <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!busy) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == gap_last) begin
                        cnt <= '0;
                        case (phase)
                            PH_INIT: begin
                                if (rom_idx != 3'd4) begin
                                    rom_idx <= rom_idx + 3'd1;
                                    state   <= S_LOAD;
                                end else if (CLEAR_EN) begin
                                    phase    <= PH_CLEAR;
                                    clr_addr <= '0;
                                    state    <= S_LOAD;
                                end else begin
                                    init_done <= 1'b1;
                                    req_ready <= 1'b1;
                                    state     <= S_IDLE;
                                end
                            end
                            PH_CLEAR: begin
                                if (clear_last) begin
                                    init_done <= 1'b1;
                                    req_ready <= 1'b1;
                                    state     <= S_IDLE;
                                end else begin
                                    clr_addr <= clr_addr + 8'd4;
                                    state    <= S_LOAD;
                                end
                            end
                            default: begin
                                req_ready <= 1'b1;
                                state     <= S_IDLE;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        // Malformed requests are consumed without a transaction.
                        req_ready <= 1'b0;
                        if (!req_drop) begin
                            in_cs     <= req_cs;
                            out_data  <= req_load_data;
                            out_count <= req_load_count;
                            phase     <= PH_REQ;
                            state     <= S_ISSUE;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_POR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ht16d35a_cmd_sequencer.sv
// tb/tb_ht16d35a_cmd_sequencer.sv - self-checking bench for ht16d35a_cmd_sequencer

module tb_ht16d35a_cmd_sequencer;

    localparam int POR      = 300;
    localparam int SETTLE   = 40;
    localparam int GAP      = 15;
    localparam int BUSY_LEN = 40;

    typedef struct packed {
        logic [1:0]       cs;
        logic [2:0]       cnt;
        logic [7:0][7:0]  data;
    } tx_t;

    typedef struct {
        logic [1:0]      cs;
        logic [7:0]      addr;
        logic [2:0]      len;
        logic [4:0][7:0] data;
        bit              drop;
        bit              slow;
        tx_t             exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            activate;
    logic [1:0]      in_cs;
    logic [7:0][7:0] out_data;
    logic [2:0]      out_count;
    logic            busy = 1'b0;
    logic            init_done;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_cs = '0;
    logic [7:0]      req_addr = '0;
    logic [4:0][7:0] req_data = '0;
    logic [2:0]      req_len = '0;

    ht16d35a_cmd_sequencer #(
        .NUM_SELECTS(2),
        .OUT_BYTES(8),
        .POR_WAIT(POR),
        .SETTLE_WAIT(SETTLE),
        .GAP_WAIT(GAP),
        .CLEAR_LAST_ADDR(8'h1F)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .activate(activate),
        .in_cs(in_cs),
        .out_data(out_data),
        .out_count(out_count),
        .busy(busy),
        .init_done(init_done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cs(req_cs),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_len(req_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model and observer, evaluated on the falling edge.
    tx_t obs_q[$];
    int  rise_q[$];
    int  fall_q[$];
    int  mstate = 0, dly = 0, bcnt = 0, delay_cfg = 3;
    int  busy_rise_cyc = 0, last_hold = 0;
    int  lat_err = 0, hold_err = 0, stab_err = 0;
    logic act_prev = 1'b0;
    tx_t cur_tx;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy = 1'b0;
            mstate = 0;
            act_prev = 1'b0;
        end else begin
            if (activate && !act_prev) begin
                rise_q.push_back(cyc);
                cur_tx = {in_cs, out_count, out_data};
                obs_q.push_back(cur_tx);
            end
            if (!activate && act_prev) begin
                if (cyc - busy_rise_cyc != 1) lat_err++;
                last_hold = cyc - rise_q[$];
            end
            act_prev = activate;
            case (mstate)
                0: if (activate) begin
                    dly = delay_cfg;
                    mstate = 1;
                end
                1: begin
                    if (!activate) hold_err++;
                    if (dly <= 1) begin
                        busy = 1'b1;
                        busy_rise_cyc = cyc;
                        bcnt = BUSY_LEN;
                        mstate = 2;
                    end else begin
                        dly--;
                    end
                end
                default: begin
                    if (bcnt <= 1) begin
                        busy = 1'b0;
                        fall_q.push_back(cyc);
                        if ({in_cs, out_count, out_data} != cur_tx) stab_err++;
                        mstate = 0;
                    end else begin
                        bcnt--;
                    end
                end
            endcase
        end
    end

    function automatic tx_t mk(input logic [1:0] cs, input logic [2:0] cnt,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] b4, input logic [7:0] b5,
                               input logic [7:0] b6);
        tx_t t;
        t.cs = cs;
        t.cnt = cnt;
        t.data = '0;
        t.data[0] = b0; t.data[1] = b1; t.data[2] = b2; t.data[3] = b3;
        t.data[4] = b4; t.data[5] = b5; t.data[6] = b6;
        return t;
    endfunction

    function automatic vec_t mkv(input logic [1:0] cs, input logic [7:0] addr,
                                 input logic [2:0] len, input logic [4:0][7:0] data,
                                 input bit drop, input bit slow, input tx_t exp);
        vec_t v;
        v.cs = cs; v.addr = addr; v.len = len; v.data = data;
        v.drop = drop; v.slow = slow; v.exp = exp;
        return v;
    endfunction

    task automatic wait_init(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (init_done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic check_init(input string tag, input int r, input int dcyc, input tx_t exp_init[$]);
        check({tag, "_init_done"}, init_done, 1'b1);
        check({tag, "_n_tx"}, obs_q.size(), exp_init.size());
        for (int i = 0; i < obs_q.size() && i < exp_init.size(); i++) begin
            check($sformatf("%s_tx%0d_cs", tag, i), obs_q[i].cs, exp_init[i].cs);
            check($sformatf("%s_tx%0d_cnt", tag, i), obs_q[i].cnt, exp_init[i].cnt);
            check($sformatf("%s_tx%0d_data", tag, i), obs_q[i].data, exp_init[i].data);
        end
        if (rise_q.size() > 0) check({tag, "_por_wait"}, (rise_q[0] - r) >= POR, 1'b1);
        for (int i = 0; i + 1 < rise_q.size() && i < fall_q.size(); i++) begin
            check($sformatf("%s_gap%0d", tag, i),
                  (rise_q[i + 1] - fall_q[i]) >= ((i == 0) ? SETTLE + 2 : GAP + 2), 1'b1);
        end
        if (fall_q.size() > 0) check({tag, "_done_after_gap"}, (dcyc - fall_q[$]) >= GAP, 1'b1);
    endtask

    tx_t  exp_init[$];
    vec_t vecs[5];
    int   r, dcyc, c0, k;

    initial begin
        exp_init.push_back(mk(2'b11, 3'd1, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        exp_init.push_back(mk(2'b11, 3'd2, 8'h35, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        exp_init.push_back(mk(2'b11, 3'd2, 8'h41, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        exp_init.push_back(mk(2'b11, 3'd2, 8'h37, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        exp_init.push_back(mk(2'b11, 3'd2, 8'h35, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
`ifdef HT16D35A_SEQ_CLEAR_EN
        for (int a = 0; a <= 8'h1C; a += 4) begin
            exp_init.push_back(mk(2'b11, 3'd6, 8'h80, 8'(a), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        end
`endif
        vecs[0] = mkv(2'b01, 8'h10, 3'd3, {8'h00, 8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b0, 1'b1,
                      mk(2'b01, 3'd5, 8'h80, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00));
        vecs[1] = mkv(2'b01, 8'h20, 3'd0, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b1, 1'b0, '0);
        vecs[2] = mkv(2'b01, 8'h20, 3'd6, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b1, 1'b0, '0);
        vecs[3] = mkv(2'b00, 8'h20, 3'd2, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b1, 1'b0, '0);
        vecs[4] = mkv(2'b10, 8'h40, 3'd5, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 1'b0,
                      mk(2'b10, 3'd7, 8'h80, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55));

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_activate", activate, 1'b0);
        check("rst_in_cs", in_cs, 2'b00);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_count", out_count, 3'd0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);

        // Power-up init sequence.
        r = cyc;
        reset_n = 1'b1;
        wait_init(6000, dcyc);
        check_init("init", r, dcyc, exp_init);

        // Write requests, including malformed ones that must be dropped.
        for (int i = 0; i < 5; i++) begin
            obs_q.delete(); rise_q.delete(); fall_q.delete();
            delay_cfg = vecs[i].slow ? 20 : 3;
            @(negedge clk);
            check($sformatf("v%0d_ready_before", i), req_ready, 1'b1);
            req_valid = 1'b1;
            req_cs = vecs[i].cs;
            req_addr = vecs[i].addr;
            req_len = vecs[i].len;
            req_data = vecs[i].data;
            c0 = cyc;
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("v%0d_ready_drop", i), req_ready, 1'b0);
            if (vecs[i].drop) begin
                @(negedge clk);
                check($sformatf("v%0d_ready_back", i), req_ready, 1'b1);
                check($sformatf("v%0d_no_activate", i), rise_q.size(), 0);
            end else begin
                k = 0;
                while (k < 2000 && !(fall_q.size() > 0 && req_ready)) begin
                    @(negedge clk);
                    k++;
                end
                check($sformatf("v%0d_n_tx", i), obs_q.size(), 1);
                if (obs_q.size() > 0) begin
                    check($sformatf("v%0d_cs", i), obs_q[0].cs, vecs[i].exp.cs);
                    check($sformatf("v%0d_cnt", i), obs_q[0].cnt, vecs[i].exp.cnt);
                    check($sformatf("v%0d_data", i), obs_q[0].data, vecs[i].exp.data);
                    check($sformatf("v%0d_accept_to_activate", i), rise_q[0] - c0, 2);
                    check($sformatf("v%0d_activate_hold", i), last_hold, delay_cfg + 1);
                end
            end
        end

        // Reset while waiting for busy to fall, then full re-init.
        delay_cfg = 3;
        @(negedge clk);
        req_valid = 1'b1;
        req_cs = 2'b10;
        req_addr = 8'h30;
        req_len = 3'd1;
        req_data = {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (k < 200 && !(busy && !activate)) begin
            @(negedge clk);
            k++;
        end
        check("mid_in_wait_lo", busy && !activate, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_activate", activate, 1'b0);
        check("async_in_cs", in_cs, 2'b00);
        check("async_out_data", out_data, 64'h0);
        check("async_out_count", out_count, 3'd0);
        check("async_init_done", init_done, 1'b0);
        check("async_req_ready", req_ready, 1'b0);
        repeat (3) @(negedge clk);
        obs_q.delete(); rise_q.delete(); fall_q.delete();
        r = cyc;
        reset_n = 1'b1;
        wait_init(6000, dcyc);
        check_init("reinit", r, dcyc, exp_init);

        check("busy_to_activate_fall_latency_errors", lat_err, 0);
        check("activate_dropped_before_busy_errors", hold_err, 0);
        check("outputs_unstable_during_busy_errors", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
